uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Parametrised UART transmit framer: accepts a parallel word on a valid/ready handshake and emits a complete asynchronous frame (start bit, data, optional parity, stop bits) on the serial line. Bit length is set by an oversampling tick count. This is the next generation of the transmitter data path. It replaces the externally indexed bit-select serializer with a self-sequencing shift register and FSM. It sits between the processor-side TX buffer and the `tx` pin, driven by the shared baud generator.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, 16: number of `baud_tick` pulses per bit period, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `MSB_FIRST`, 0: 0 sends LSB first (standard UART); 1 sends MSB first.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  single-cycle oversample enable from the baud generator.
- `tx_data`  in  DATA_WIDTH  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  framer can accept a word; high only in IDLE.
- `par_en`  in  1  append a parity bit; sampled at acceptance.
- `par_odd`  in  1  1 selects odd parity, 0 selects even; sampled at acceptance.
- `tx`  out  1  registered serial line; idles high.
- `busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Handshake: a word is accepted when `tx_valid && tx_ready`. On acceptance:
  - `tx_data` is captured into the shift register.
  - `par_en`/`par_odd` are latched; parity = ^data XOR `par_odd`.
  - The tick counter and bit counter are cleared.
  - The FSM moves to START.
- Each bit lasts exactly OVERSAMPLE `baud_tick` pulses. The bit ends in the cycle that sees the OVERSAMPLE-th tick. The next bit's value appears on `tx` in the following cycle.
- State transitions:
  - START (`tx`=0) goes to DATA.
  - DATA shifts out DATA_WIDTH bits (LSB or MSB first according to `MSB_FIRST`), then goes to PARITY if `par_en` was latched, otherwise to STOP.
  - PARITY drives the latched parity bit, then goes to STOP.
  - STOP (`tx`=1) lasts STOP_BITS×OVERSAMPLE ticks, then goes to IDLE.
- Changes on `tx_data`, `par_en` or `par_odd` while busy are ignored.
- `tx_valid` while not ready is held off; no word is dropped or duplicated.
- `baud_tick` in IDLE is ignored. The tick counter starts from zero at acceptance, so the start bit is always full length.
- Tick counter width is $clog2(OVERSAMPLE); it wraps to 0 at OVERSAMPLE-1 on a tick. Bit counter width is $clog2(DATA_WIDTH+1).

## Timing
- Reset values: `tx`=1, `busy`=0, `tx_ready`=1; state IDLE; counters 0.
- Reset asserted mid-frame forces `tx`=1 asynchronously and discards the frame.
- Latency: acceptance at edge k gives `tx`=0 and `busy`=1 from edge k+1.
- Frame length: (1 + DATA_WIDTH + par_en + STOP_BITS) × OVERSAMPLE ticks.
- Completion: the last stop tick at edge m puts IDLE (`tx_ready`=1) at m+1. A held `tx_valid` is accepted at m+1, so the next start bit begins at m+2. This gives exactly one clk of idle between back-to-back frames.
- `tx_ready` is combinational from state, and accepting does not depend on `tx_ready` feeding back into `tx_valid`.

## Structure
- Package `uart_pkg`: the state enum `uart_tx_state_t`, parity-mode constants `PAR_EVEN=0` and `PAR_ODD=1`, and the default OVERSAMPLE value. These are shared with the receiver.
- Sub-module `uart_bit_timer`: counts `baud_tick` up to OVERSAMPLE, clears on a start pulse, and outputs a `bit_done` strobe. The receiver reuses it.
- The FSM, shift register and parity logic live in the top module.

## Test plan
- Defaults, `baud_tick` high every cycle, send 0xA5 with `par_en`=0:
  - `tx` must read 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles.
  - `busy` is high for 160 cycles.
  - `tx_ready` returns high at cycle 161.
- `par_en`=1: 0x07 with `par_odd`=0 gives parity bit 1. 0x03 with `par_odd`=1 gives parity bit 1. 0x00 with `par_odd`=0 gives parity bit 0. Each frame is 11 bits.
- `MSB_FIRST`=1, `STOP_BITS`=2, `DATA_WIDTH`=7, send 0x40:
  - The first data bit is 1, followed by six 0s.
  - The stop phase lasts 32 ticks.
- `baud_tick` every 3rd cycle, `OVERSAMPLE`=4: each bit lasts 12 cycles. Changing `tx_data` mid-frame has no effect on `tx`.
- Back-to-back: `tx_valid` held high with 0x55 then 0xAA. Exactly one idle clk with `tx`=1 separates the last stop bit of the first frame from the next start bit. Both words are sent in order.
- Assert `reset_n` low during data bit 3: `tx`=1 and `busy`=0 immediately. After release, a new 0x3C frame transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, parity-mode
// constants and the default oversample ratio (also used by the receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts enabled baud ticks and strobes bit_done_o on the
// OVERSAMPLE-th one. Ports: clk, reset_n, start_i (clear), en_i, tick_i,
// bit_done_o (single-cycle, combinational from the current tick).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic en_i,
    input  logic tick_i,
    output logic bit_done_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d      = cnt_q;
        bit_done_o = 1'b0;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            if (cnt_q == LAST) begin
                cnt_d      = '0;
                bit_done_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmit framer: takes a word on tx_valid/tx_ready and sends start,
// data (LSB or MSB first), optional parity and stop bits on the tx line.
// Ports: clk, reset_n, baud_tick, tx_data/tx_valid/tx_ready, par_en,
// par_odd, tx (registered, idles high), busy.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_tx_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;

    logic                  accept;
    logic                  bit_done;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  head_bit;
    logic                  next_bit;

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = ~tx_ready;
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_q;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (accept),
        .en_i      (busy),
        .tick_i    (baud_tick),
        .bit_done_o(bit_done)
    );

    // The bit on the line is always the output end of shreg_q; shifting
    // exposes the following bit at that same end.
    always_comb begin
        if (MSB_FIRST) begin
            head_bit = shreg_q[DATA_WIDTH-1];
            next_bit = shreg_q[DATA_WIDTH-2];
            shifted  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            head_bit = shreg_q[0];
            next_bit = shreg_q[1];
            shifted  = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        end
    end

    // tx_d is the value for the next cycle, so each bit appears on the line
    // the cycle after the previous bit's last tick.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = tx_data;
                    bcnt_d    = '0;
                    par_en_d  = par_en;
                    par_bit_d = (^tx_data) ^ (par_odd == PAR_ODD);
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = head_bit;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bcnt_q == LAST_DATA) begin
                        bcnt_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                        shreg_d = shifted;
                        tx_d    = next_bit;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (bcnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bcnt_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bcnt_q    <= bcnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: two instances (default 8N1/x16 and
// 7-bit MSB-first, 2 stop, x4) checked against a frame-level model.
module tb_uart_frame_tx;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] bt, vld, pe, po, rdy, txl, bsy;
    logic [7:0] d0;
    logic [6:0] d1;

    int tests = 0;
    int errs  = 0;
    int tmode = 1;

    frame_t q0[$];
    frame_t q1[$];

    always #5 clk = ~clk;

    uart_frame_tx dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .baud_tick(bt[0]),
        .tx_data (d0),
        .tx_valid(vld[0]),
        .tx_ready(rdy[0]),
        .par_en  (pe[0]),
        .par_odd (po[0]),
        .tx      (txl[0]),
        .busy    (bsy[0])
    );

    uart_frame_tx #(
        .DATA_WIDTH(7),
        .OVERSAMPLE(4),
        .STOP_BITS (2),
        .MSB_FIRST (1'b1)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .baud_tick(bt[1]),
        .tx_data (d1),
        .tx_valid(vld[1]),
        .tx_ready(rdy[1]),
        .par_en  (pe[1]),
        .par_odd (po[1]),
        .tx      (txl[1]),
        .busy    (bsy[1])
    );

    function automatic void chk(input string nm, input int g,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d: got %0h expected %0h",
                     nm, g, act, exp);
        end
    endfunction

    function automatic void fail(input string nm, input int g);
        tests++;
        errs++;
        $display("FAIL %s dut%0d: got timeout/none expected event", nm, g);
    endfunction

    // Reference frame: start 0, data bits in wire order, parity making
    // the ones count even (or odd), then the stop bits as 1s.
    function automatic frame_t mk(input int g, input logic [8:0] d,
                                  input bit pe_b, input bit po_b);
        int dw = (g == 0) ? 8 : 7;
        int sb = (g == 0) ? 1 : 2;
        bit msb = (g == 1);
        int ones = 0;
        frame_t f;
        f.bits = '1;
        f.n = 0;
        f.bits[f.n] = 1'b0;
        f.n++;
        for (int i = 0; i < dw; i++) begin
            f.bits[f.n] = msb ? d[dw-1-i] : d[i];
            ones += int'(d[i]);
            f.n++;
        end
        if (pe_b) begin
            f.bits[f.n] = 1'((ones % 2) ^ int'(po_b));
            f.n++;
        end
        f.n += sb;
        return f;
    endfunction

    initial begin
        int c = 0;
        bt = '0;
        forever begin
            @(posedge clk);
            #1;
            bt[0] = (tmode == 1) ? 1'b1 :
                    (tmode == 2) ? 1'($urandom) : 1'b0;
            bt[1] = (c % 3 == 2);
            c++;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int OS = (g == 0) ? 16 : 4;
        frame_t cur;
        bit inframe = 1'b0;
        bit chk_end = 1'b0;
        int bi = 0;
        int tc = 0;
        int gap = 0;
        int last_gap = -1;

        always @(negedge clk) begin
            if (!reset_n) begin
                inframe = 1'b0;
                chk_end = 1'b0;
                gap = 0;
            end else begin
                if (chk_end) begin
                    chk_end = 1'b0;
                    chk("end_busy", g, 32'(bsy[g]), 0);
                    chk("end_ready", g, 32'(rdy[g]), 1);
                end
                if (!inframe && bsy[g]) begin
                    if (g == 0 && q0.size() > 0) begin
                        cur = q0.pop_front();
                        inframe = 1'b1;
                    end else if (g == 1 && q1.size() > 0) begin
                        cur = q1.pop_front();
                        inframe = 1'b1;
                    end else begin
                        fail("unexpected_frame", g);
                    end
                    if (inframe) begin
                        bi = 0;
                        tc = 0;
                        last_gap = gap;
                    end
                end
                if (inframe) begin
                    chk("busy_in_frame", g, 32'(bsy[g]), 1);
                    chk("ready_in_frame", g, 32'(rdy[g]), 0);
                    chk($sformatf("tx_bit%0d", bi), g,
                        32'(txl[g]), 32'(cur.bits[bi]));
                    if (bt[g]) begin
                        tc++;
                        if (tc == OS) begin
                            tc = 0;
                            bi++;
                            if (bi == cur.n) begin
                                inframe = 1'b0;
                                chk_end = 1'b1;
                                gap = 0;
                            end
                        end
                    end
                end else if (!bsy[g]) begin
                    gap++;
                    chk("idle_tx", g, 32'(txl[g]), 1);
                end
            end
        end
    end

    task automatic send(input int g, input logic [8:0] d,
                        input bit pe_b, input bit po_b, input bit hold);
        int n = 0;
        if (g == 0) d0 = d[7:0];
        else        d1 = d[6:0];
        pe[g]  = pe_b;
        po[g]  = po_b;
        vld[g] = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy[g]) break;
            n++;
            if (n > 3000) begin
                fail("ready_timeout", g);
                vld[g] = 1'b0;
                return;
            end
        end
        if (g == 0) q0.push_back(mk(0, d, pe_b, po_b));
        else        q1.push_back(mk(1, d, pe_b, po_b));
        @(posedge clk);
        #1;
        if (!hold) vld[g] = 1'b0;
    endtask

    function automatic bit pending(input int g);
        if (g == 0) return q0.size() != 0 || mon[0].inframe || bsy[0];
        return q1.size() != 0 || mon[1].inframe || bsy[1];
    endfunction

    task automatic wait_idle(input int g, input bit scramble);
        int n = 0;
        while (pending(g)) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                if (g == 0) d0 = 8'($urandom);
                else        d1 = 7'($urandom);
                pe[g] = 1'($urandom);
                po[g] = 1'($urandom);
            end
            n++;
            if (n > 4000) begin
                fail("idle_timeout", g);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog dut0: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        vld = '0;
        pe = '0;
        po = '0;
        d0 = '0;
        d1 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_tx", g, 32'(txl[g]), 1);
            chk("reset_busy", g, 32'(bsy[g]), 0);
            chk("reset_ready", g, 32'(rdy[g]), 1);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (bsy[0] && n < 400) begin
            @(negedge clk);
            if (bsy[0]) n++;
        end
        chk("busy_cycles", 0, n, 160);
        @(posedge clk);
        #1;
        wait_idle(0, 1'b0);

        send(0, 9'h007, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 1'b1);
        send(0, 9'h003, 1'b1, 1'b1, 1'b0);
        wait_idle(0, 1'b1);
        send(0, 9'h000, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 1'b1);

        send(1, 9'h040, 1'b0, 1'b0, 1'b0);
        wait_idle(1, 1'b1);

        send(0, 9'h055, 1'b0, 1'b0, 1'b1);
        send(0, 9'h0AA, 1'b0, 1'b0, 1'b0);
        wait_idle(0, 1'b0);
        chk("b2b_gap", 0, mon[0].last_gap, 1);

        send(0, 9'h05A, 1'b0, 1'b0, 1'b0);
        repeat (70) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tx", 0, 32'(txl[0]), 1);
        chk("rst_mid_busy", 0, 32'(bsy[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 9'h03C, 1'b0, 1'b0, 1'b0);
        wait_idle(0, 1'b0);

        tmode = 2;
        for (int i = 0; i < 30; i++) begin
            bit hold = 1'($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            send(0, 9'($urandom), 1'($urandom), 1'($urandom), hold);
            if (!hold) wait_idle(0, 1'b1);
        end
        vld[0] = 1'b0;
        wait_idle(0, 1'b0);
        tmode = 1;

        for (int i = 0; i < 15; i++) begin
            bit hold = 1'($urandom_range(0, 2) == 0);
            send(1, 9'($urandom), 1'($urandom), 1'($urandom), hold);
            if (!hold) wait_idle(1, 1'b1);
        end
        vld[1] = 1'b0;
        wait_idle(1, 1'b0);

        repeat (4) @(posedge clk);
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
